// File: rtl/axi_ddr_slave.sv
// rtl/axi_ddr_slave.sv - AXI4 slave memory model for the 128-bit DDR master port
// Independent read and write engines over a line-addressed backing store with programmable latency.
module axi_ddr_slave #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128,
    parameter int MEM_LINES = 4096,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWLOCK,
    input  logic [3:0]          S_AXI_AWCACHE,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic [3:0]          S_AXI_AWQOS,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARLOCK,
    input  logic [3:0]          S_AXI_ARCACHE,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic [3:0]          S_AXI_ARQOS,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam logic [7:0] WR_WAIT = 8'(WR_LAT - 2);
    localparam logic [7:0] RD_WAIT = 8'(RD_LAT - 2);
    localparam logic [1:0] SLVERR  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [MEM_LINES];

    wire unused_ok = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                       S_AXI_AWQOS, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

    // ---------------- write engine ----------------
    w_state_t         w_state, w_next;
    logic             aw_ready;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len, w_beat, w_cnt;
    logic             w_fixed, w_aerr, w_lerr;
    logic             aw_hs, w_hs, w_last_beat;

    assign aw_hs       = aw_ready && S_AXI_AWVALID;
    assign w_hs        = (w_state == W_DATA) && S_AXI_WVALID;
    assign w_last_beat = (w_beat == w_len);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = (WR_LAT == 1) ? W_RESP : W_LAT;
            W_LAT:   if (w_cnt == WR_WAIT) w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_idx    <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_cnt    <= '0;
            w_fixed  <= 1'b0;
            w_aerr   <= 1'b0;
            w_lerr   <= 1'b0;
        end else begin
            w_state  <= w_next;
            aw_ready <= (w_next == W_IDLE);
            w_cnt    <= (w_state == W_LAT) ? w_cnt + 8'd1 : 8'd0;
            if (aw_hs) begin
                w_idx   <= S_AXI_AWADDR[IDX_W+3:4];
                w_len   <= S_AXI_AWLEN;
                w_fixed <= (S_AXI_AWBURST == 2'b00);
                w_aerr  <= (S_AXI_AWSIZE != 3'b100) || (S_AXI_AWBURST == 2'b10);
                w_lerr  <= 1'b0;
                w_beat  <= '0;
            end
            if (w_hs) begin
                w_beat <= w_beat + 8'd1;
                if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
                if (S_AXI_WLAST != w_last_beat) w_lerr <= 1'b1;
            end
        end
    end

    // A WLAST mismatch still commits data; only address-phase errors suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && w_hs && !w_aerr) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (S_AXI_WSTRB[i]) mem[w_idx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = (w_state == W_DATA);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && (w_aerr || w_lerr)) ? SLVERR : 2'b00;

    // ---------------- read engine ----------------
    r_state_t          r_state, r_next;
    logic              ar_ready, r_load;
    logic [IDX_W-1:0]  r_idx, cur_idx;
    logic [7:0]        r_len, r_beat, r_cnt, cur_len, cur_beat;
    logic              r_fixed, r_err, cur_fixed, cur_err;
    logic              ar_hs, r_hs;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid;

    assign ar_hs = ar_ready && S_AXI_ARVALID;
    assign r_hs  = rvalid && S_AXI_RREADY;

    // With RD_LAT==1 beat 0 loads on the AR handshake itself, before the latches hold the request.
    always_comb begin
        if (r_state == R_IDLE) begin
            cur_idx   = S_AXI_ARADDR[IDX_W+3:4];
            cur_len   = S_AXI_ARLEN;
            cur_beat  = 8'd0;
            cur_fixed = (S_AXI_ARBURST == 2'b00);
            cur_err   = (S_AXI_ARSIZE != 3'b100) || (S_AXI_ARBURST == 2'b10);
        end else begin
            cur_idx   = r_idx;
            cur_len   = r_len;
            cur_beat  = r_beat;
            cur_fixed = r_fixed;
            cur_err   = r_err;
        end
    end

    always_comb begin
        r_next = r_state;
        r_load = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    if (RD_LAT == 1) begin
                        r_next = R_DATA;
                        r_load = 1'b1;
                    end else begin
                        r_next = R_LAT;
                    end
                end
            end
            R_LAT: begin
                if (r_cnt == RD_WAIT) begin
                    r_next = R_DATA;
                    r_load = 1'b1;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast) r_next = R_IDLE;
                    else       r_load = 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_idx    <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_cnt    <= '0;
            r_fixed  <= 1'b0;
            r_err    <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
            rlast    <= 1'b0;
            rvalid   <= 1'b0;
        end else begin
            r_state  <= r_next;
            ar_ready <= (r_next == R_IDLE);
            r_cnt    <= (r_state == R_LAT) ? r_cnt + 8'd1 : 8'd0;
            if (ar_hs) begin
                r_idx   <= cur_idx;
                r_len   <= cur_len;
                r_beat  <= 8'd0;
                r_fixed <= cur_fixed;
                r_err   <= cur_err;
            end
            if (r_load) begin
                rdata  <= cur_err ? '0 : mem[cur_idx];
                rresp  <= cur_err ? SLVERR : 2'b00;
                rlast  <= (cur_beat == cur_len);
                rvalid <= 1'b1;
                r_idx  <= cur_fixed ? cur_idx : cur_idx + IDX_W'(1);
                r_beat <= cur_beat + 8'd1;
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
                rresp  <= 2'b00;
            end
        end
    end

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RLAST   = rlast;
    assign S_AXI_RVALID  = rvalid;
endmodule

// File: tb/tb_axi_ddr_slave.sv
// tb/tb_axi_ddr_slave.sv - directed self-checking bench for axi_ddr_slave
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_ddr_slave;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic         clk, rst;
    logic [26:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic [1:0]   bresp, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    int vectors = 0;
    int miscompares = 0;
    int lat;

    localparam logic [127:0] D1 = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] BA = 128'haaaa0000_00000000_00000000_0000aaaa;
    localparam logic [127:0] BB = 128'hbbbb1111_11111111_11111111_1111bbbb;
    localparam logic [127:0] BC = 128'hcccc2222_22222222_22222222_2222cccc;
    localparam logic [127:0] BD = 128'hdddd3333_33333333_33333333_3333dddd;
    localparam logic [127:0] DE = 128'heeeeeeee_eeeeeeee_00000000_12345678;
    localparam logic [127:0] DF = 128'hffff0000_ffff0000_ffff0000_ffff0000;
    localparam logic [127:0] DG = 128'h99990000_00000000_00000000_00000001;
    localparam logic [127:0] DH = 128'h88880000_00000000_00000000_00000002;
    localparam logic [127:0] ONES = '1;

    axi_ddr_slave #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0), .S_AXI_AWQOS(4'h0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0), .S_AXI_ARQOS(4'h0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_aw(input logic [26:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) tick;
        chk("awready", awready, 1);
        tick;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [127:0] d, input logic [15:0] s, input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) tick;
        chk("wready", wready, 1);
        tick;
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [1:0] exp, output int n);
        n = 0;
        while (!bvalid && n < 50) begin tick; n++; end
        chk({tag, "_bvalid"}, bvalid, 1);
        chk({tag, "_bresp"}, bresp, exp);
        bready = 1'b1;
        tick;
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [26:0] a, input logic [7:0] len, input logic [1:0] burst);
        araddr = a; arlen = len; arsize = 3'b100; arburst = burst; arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) tick;
        chk("arready", arready, 1);
        tick;
        arvalid = 1'b0;
    endtask

    task automatic rd_beat(input string tag, input logic [127:0] d, input logic [1:0] resp,
                           input logic last, output int n);
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin tick; n++; end
        chk({tag, "_rvalid"}, rvalid, 1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rresp"}, rresp, resp);
        chk({tag, "_rlast"}, rlast, last);
        tick;
    endtask

    task automatic write1(input logic [26:0] a, input logic [127:0] d, input logic [15:0] s);
        do_aw(a, 8'd0, 3'b100, 2'b01);
        do_w(d, s, 1'b1);
        wait_b("wr1", 2'b00, lat);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = 3'b100; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = 3'b100; arburst = 2'b01; arvalid = 1'b0; rready = 1'b1;
        tick; tick; tick;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rresp", rresp, 0);
        rst = 1'b0;
        tick;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);

        // 1: single write then read back, with latencies
        do_aw(27'h0000120, 8'd0, 3'b100, 2'b01);
        do_w(D1, 16'hffff, 1'b1);
        wait_b("t1", 2'b00, lat);
        chk("t1_b_latency", 128'(lat), 128'(WR_LAT - 1));
        do_ar(27'h0000120, 8'd0, 2'b01);
        rd_beat("t1_rd", D1, 2'b00, 1'b1, lat);
        chk("t1_r_latency", 128'(lat), 128'(RD_LAT - 1));
        chk("t1_rvalid_drop", rvalid, 0);

        // 2: partial strobe over an all-ones line
        write1(27'h0000200, ONES, 16'hffff);
        write1(27'h0000200, '0, 16'h000f);
        do_ar(27'h0000200, 8'd0, 2'b01);
        rd_beat("t2_rd", 128'hffffffff_ffffffff_ffffffff_00000000, 2'b00, 1'b1, lat);

        // 3: INCR burst wrapping from line 4094 to line 1
        do_aw(27'h000ffe0, 8'd3, 3'b100, 2'b01);
        do_w(BA, 16'hffff, 1'b0);
        do_w(BB, 16'hffff, 1'b0);
        do_w(BC, 16'hffff, 1'b0);
        do_w(BD, 16'hffff, 1'b1);
        wait_b("t3", 2'b00, lat);
        do_ar(27'h0000000, 8'd0, 2'b01);
        rd_beat("t3_line0", BC, 2'b00, 1'b1, lat);
        do_ar(27'h0000010, 8'd0, 2'b01);
        rd_beat("t3_line1", BD, 2'b00, 1'b1, lat);
        do_ar(27'h001ffe5, 8'd0, 2'b01);
        rd_beat("t3_alias4094", BA, 2'b00, 1'b1, lat);
        do_ar(27'h000ffe0, 8'd3, 2'b01);
        rd_beat("t3_b0", BA, 2'b00, 1'b0, lat);
        rd_beat("t3_b1", BB, 2'b00, 1'b0, lat);
        rd_beat("t3_b2", BC, 2'b00, 1'b0, lat);
        rd_beat("t3_b3", BD, 2'b00, 1'b1, lat);

        // 4: read backpressure with RREADY 1,0,0,1
        rready = 1'b0;
        do_ar(27'h000ffe0, 8'd3, 2'b01);
        for (int n = 0; n < 50 && !rvalid; n++) tick;
        chk("t4_a_data", rdata, BA);
        rready = 1'b1; tick;
        chk("t4_b_data", rdata, BB);
        rready = 1'b0; tick;
        chk("t4_b_hold1", rdata, BB);
        chk("t4_b_hold1_last", rlast, 0);
        tick;
        chk("t4_b_hold2", rdata, BB);
        chk("t4_b_hold2_valid", rvalid, 1);
        rready = 1'b1; tick;
        chk("t4_c_data", rdata, BC);
        tick;
        chk("t4_d_data", rdata, BD);
        chk("t4_d_last", rlast, 1);
        tick;
        chk("t4_done", rvalid, 0);

        // 4/5: BREADY held low on a SIZE error, memory left untouched
        write1(27'h0000600, DE, 16'hffff);
        do_aw(27'h0000600, 8'd0, 3'b010, 2'b01);
        do_w(DF, 16'hffff, 1'b1);
        for (int n = 0; n < 50 && !bvalid; n++) tick;
        for (int i = 0; i < 5; i++) begin
            chk("t5_b_hold_valid", bvalid, 1);
            chk("t5_b_hold_resp", bresp, 2'b10);
            tick;
        end
        bready = 1'b1; tick; bready = 1'b0;
        chk("t5_b_release", bvalid, 0);
        do_ar(27'h0000600, 8'd0, 2'b01);
        rd_beat("t5_unchanged", DE, 2'b00, 1'b1, lat);

        // 5: WRAP read burst is an error returning zero data
        do_ar(27'h0000120, 8'd1, 2'b10);
        rd_beat("t5_wrap0", '0, 2'b10, 1'b0, lat);
        rd_beat("t5_wrap1", '0, 2'b10, 1'b1, lat);

        // 5: early WLAST on beat 0 of a two-beat burst; data still lands
        do_aw(27'h0000300, 8'd1, 3'b100, 2'b01);
        do_w(DG, 16'hffff, 1'b1);
        do_w(DH, 16'hffff, 1'b0);
        wait_b("t5_wlast", 2'b10, lat);
        do_ar(27'h0000300, 8'd1, 2'b01);
        rd_beat("t5_wl_b0", DG, 2'b00, 1'b0, lat);
        rd_beat("t5_wl_b1", DH, 2'b00, 1'b1, lat);

        // 6: reset during beat 1 of a 4-beat read
        do_ar(27'h000ffe0, 8'd3, 2'b01);
        rd_beat("t6_b0", BA, 2'b00, 1'b0, lat);
        chk("t6_b1_data", rdata, BB);
        rst = 1'b1;
        tick;
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_arready", arready, 0);
        rst = 1'b0;
        tick;
        chk("t6_arready", arready, 1);
        chk("t6_rvalid_after", rvalid, 0);
        tick; tick;
        chk("t6_no_more_beats", rvalid, 0);
        do_ar(27'h0000120, 8'd0, 2'b01);
        rd_beat("t6_recover", D1, 2'b00, 1'b1, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
